// File: rtl/xmem_port_arb_pkg.sv
// Shared definitions for the xmem host-port arbiter: controller states and
// the xmem read latency that the response pipeline is built around.
package xmem_port_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  localparam int XMEM_RD_LAT = 2;

endpackage

// File: rtl/xmem_port_arb_if.sv
// Host-side bus of the xmem port arbiter: requester handshakes plus the
// memory port the arbiter drives.
interface xmem_port_arb_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_rdata;

  logic                    mem_valid;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_q;

  // Requesters together with the memory model sit on the master side.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_q,
    input  req_ready, rsp_valid, rsp_rdata,
           mem_valid, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_q,
    output req_ready, rsp_valid, rsp_rdata,
           mem_valid, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/xmem_port_arb_xrr_arb.sv
// Round-robin one-hot selector: the requester at index ptr has the highest
// priority, then ptr+1, wrapping modulo N_REQ.
module xrr_arb #(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt
);

  // Walk from lowest to highest priority so the last hit wins.
  always_comb begin
    gnt = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i] && (((int'(ptr) + k) % N_REQ) == i)) begin
          gnt = N_REQ'(1) << i;
        end
      end
    end
  end

endmodule

// File: rtl/xmem_port_arb.sv
// Shares the xmem host port between N_REQ requesters while idle and hands
// the memory to the engine between a run pulse and both done flags.
module xmem_port_arb
  import xmem_port_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          doneA,
  input  logic          doneB,
  output logic          busy,
  xmem_port_arb_if.slave bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e             state_q, state_d;
  logic                   first_q, first_d;
  logic                   done_a_q, done_a_d;
  logic                   done_b_q, done_b_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [XMEM_RD_LAT-1:0] rd_vld_q, rd_vld_d;
  logic [PTR_W-1:0]       rd_own_q [XMEM_RD_LAT];
  logic [PTR_W-1:0]       rd_own_d [XMEM_RD_LAT];

  logic                   grant_en;
  logic [N_REQ-1:0]       rr_gnt;
  logic [N_REQ-1:0]       gnt_vec;
  logic [PTR_W-1:0]       gnt_idx;
  logic                   xfer;
  logic                   sel_we;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic [N_REQ-1:0]       rsp_vec;

  xrr_arb #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (rr_gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      first_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
    end
  end

  // Done levels seen in the first RUN cycle may be left over from the
  // previous run, so the sticky flags only start collecting one cycle later.
  always_comb begin
    state_d  = state_q;
    first_d  = 1'b0;
    done_a_d = done_a_q;
    done_b_d = done_b_q;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d  = ST_RUN;
          first_d  = 1'b1;
          done_a_d = 1'b0;
          done_b_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (done_a_q && done_b_q) begin
          state_d  = ST_IDLE;
          done_a_d = 1'b0;
          done_b_d = 1'b0;
        end else if (!first_q) begin
          done_a_d = done_a_q | doneA;
          done_b_d = done_b_q | doneB;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_en = !rst && (state_q == ST_IDLE) && !run;
    busy     = !rst && ((state_q == ST_RUN) || run);
  end

  always_comb begin
    gnt_vec   = grant_en ? rr_gnt : '0;
    xfer      = |gnt_vec;
    gnt_idx   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_vec[i]) begin
        gnt_idx   = PTR_W'(i);
        sel_we    = bus.req_we[i];
        sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.req_ready = gnt_vec;
  assign bus.mem_valid = xfer;
  assign bus.mem_we    = xfer & sel_we;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
    rd_vld_d[0] = xfer & ~sel_we;
    rd_own_d[0] = gnt_idx;
    for (int s = 1; s < XMEM_RD_LAT; s++) begin
      rd_vld_d[s] = rd_vld_q[s-1];
      rd_own_d[s] = rd_own_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= '0;
      rd_vld_q <= '0;
      for (int s = 0; s < XMEM_RD_LAT; s++) begin
        rd_own_q[s] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      rd_vld_q <= rd_vld_d;
      for (int s = 0; s < XMEM_RD_LAT; s++) begin
        rd_own_q[s] <= rd_own_d[s];
      end
    end
  end

  // The last pipeline stage lines up with the cycle xmem presents the word.
  always_comb begin
    rsp_vec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rd_vld_q[XMEM_RD_LAT-1] && (rd_own_q[XMEM_RD_LAT-1] == PTR_W'(i))) begin
        rsp_vec[i] = 1'b1;
      end
    end
  end

  assign bus.rsp_valid = rsp_vec;
  assign bus.rsp_rdata = rd_vld_q[XMEM_RD_LAT-1] ? bus.mem_q : '0;

endmodule

// File: tb/tb_xmem_port_arb.sv
// Directed bench for xmem_port_arb with a cycle-level reference model and an
// xmem stand-in that returns read words two cycles after the access.
module tb_xmem_port_arb;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int AW = 10;

  logic clk;
  logic rst;
  logic run;
  logic done_a;
  logic done_b;
  logic busy;

  xmem_port_arb_if #(.N_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) bus ();

  xmem_port_arb #(
    .N_REQ  (NR),
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .doneA (done_a),
    .doneB (done_b),
    .busy  (busy),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int cyc;

  int          ptr_m;
  bit          running;
  int          run_age;
  bit          seen_a;
  bit          seen_b;
  int          resp_due [int];
  logic [31:0] rdata_due [int];
  logic [31:0] mem_m [int];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("[TB] FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, want);
    end
  endtask

  task automatic applyStimulus(input logic rs, input logic [1:0] v, input logic [1:0] we,
                               input logic [9:0] a0, input logic [9:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic r, input logic da, input logic db);
    @(posedge clk);
    #1;
    rst           = rs;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {d1, d0};
    run           = r;
    done_a        = da;
    done_b        = db;
    #2;
  endtask

  function automatic logic [31:0] mem_read(input int a);
    if (mem_m.exists(a)) return mem_m[a];
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Reference model: one evaluation per cycle, at the falling edge.
  initial begin
    int          g;
    logic [1:0]  exp_ready;
    logic        exp_we;
    logic [9:0]  exp_addr;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_rsp;
    logic        exp_busy;
    cyc     = 0;
    ptr_m   = 0;
    running = 1'b0;
    run_age = 0;
    seen_a  = 1'b0;
    seen_b  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_q = rdata_due.exists(cyc) ? rdata_due[cyc] : (32'h5A5A_0000 ^ 32'(cyc));
      @(negedge clk);
      if (rst) begin
        checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd0);
        checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        checkOutput("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
        checkOutput("rst_mem_we",    64'(bus.mem_we),    64'd0);
        checkOutput("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
        checkOutput("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        checkOutput("rst_busy",      64'(busy),          64'd0);
        ptr_m   = 0;
        running = 1'b0;
        run_age = 0;
        seen_a  = 1'b0;
        seen_b  = 1'b0;
        resp_due.delete();
        rdata_due.delete();
      end else begin
        g = -1;
        if (!running && !run) begin
          for (int k = 0; k < NR; k++) begin
            if (g < 0 && bus.req_valid[(ptr_m + k) % NR]) g = (ptr_m + k) % NR;
          end
        end
        exp_ready = 2'b00;
        exp_we    = 1'b0;
        exp_addr  = '0;
        exp_wdata = '0;
        if (g >= 0) begin
          exp_ready = 2'(1 << g);
          exp_we    = bus.req_we[g];
          exp_addr  = bus.req_addr[g*AW +: AW];
          exp_wdata = bus.req_wdata[g*DW +: DW];
        end
        exp_rsp  = resp_due.exists(cyc) ? 2'(1 << resp_due[cyc]) : 2'b00;
        exp_busy = running || run;

        checkOutput("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        checkOutput("mem_valid", 64'(bus.mem_valid), 64'(g >= 0));
        checkOutput("mem_we",    64'(bus.mem_we),    64'(exp_we));
        checkOutput("mem_addr",  64'(bus.mem_addr),  64'(exp_addr));
        checkOutput("mem_wdata", 64'(bus.mem_wdata), 64'(exp_wdata));
        checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rsp));
        if (exp_rsp != 2'b00) checkOutput("rsp_rdata", 64'(bus.rsp_rdata), 64'(rdata_due[cyc]));
        checkOutput("busy", 64'(busy), 64'(exp_busy));

        if (g >= 0) begin
          if (exp_we) begin
            mem_m[int'(exp_addr)] = exp_wdata;
          end else begin
            resp_due[cyc+2]  = g;
            rdata_due[cyc+2] = mem_read(int'(exp_addr));
          end
          ptr_m = (g + 1) % NR;
        end

        if (!running) begin
          if (run) begin
            running = 1'b1;
            run_age = 0;
            seen_a  = 1'b0;
            seen_b  = 1'b0;
          end
        end else if (seen_a && seen_b) begin
          running = 1'b0;
        end else begin
          if (run_age >= 1) begin
            seen_a = seen_a | done_a;
            seen_b = seen_b | done_b;
          end
          run_age++;
        end
      end
      cyc++;
    end
  end

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst           = 1'b1;
    run           = 1'b0;
    done_a        = 1'b0;
    done_b        = 1'b0;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_q     = '0;

    // Reset held with requests pending: nothing may be granted.
    for (int i = 0; i < 3; i++) applyStimulus(1, 2'b11, 2'b00, 10'h010, 10'h020, 0, 0, 0, 0, 0);
    checkOutput("lit_rst_ready", 64'(bus.req_ready), 64'd0);
    checkOutput("lit_rst_busy",  64'(busy), 64'd0);

    // Two readers contending continuously.
    applyStimulus(0, 2'b11, 2'b00, 10'h010, 10'h020, 0, 0, 0, 0, 0);
    checkOutput("lit_rr0", 64'(bus.req_ready), 64'h1);
    applyStimulus(0, 2'b11, 2'b00, 10'h010, 10'h020, 0, 0, 0, 0, 0);
    checkOutput("lit_rr1", 64'(bus.req_ready), 64'h2);
    applyStimulus(0, 2'b11, 2'b00, 10'h010, 10'h020, 0, 0, 0, 0, 0);
    checkOutput("lit_rr2", 64'(bus.req_ready), 64'h1);
    checkOutput("lit_rsp0", 64'(bus.rsp_valid), 64'h1);
    checkOutput("lit_rsp0_data", 64'(bus.rsp_rdata), 64'hC0DE_0010);
    applyStimulus(0, 2'b11, 2'b00, 10'h010, 10'h020, 0, 0, 0, 0, 0);
    checkOutput("lit_rr3", 64'(bus.req_ready), 64'h2);
    checkOutput("lit_rsp1", 64'(bus.rsp_valid), 64'h2);
    checkOutput("lit_rsp1_data", 64'(bus.rsp_rdata), 64'hC0DE_0020);
    for (int i = 0; i < 2; i++) applyStimulus(0, 2'b11, 2'b00, 10'h010, 10'h020, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);

    // Write from requester 1 to the top word, read back by requester 0.
    applyStimulus(0, 2'b10, 2'b10, 0, 10'h3FF, 0, 32'hDEAD_BEEF, 0, 0, 0);
    checkOutput("lit_wr_ready", 64'(bus.req_ready), 64'h2);
    checkOutput("lit_wr_we",    64'(bus.mem_we), 64'h1);
    checkOutput("lit_wr_addr",  64'(bus.mem_addr), 64'h3FF);
    checkOutput("lit_wr_data",  64'(bus.mem_wdata), 64'hDEAD_BEEF);
    applyStimulus(0, 2'b01, 2'b00, 10'h3FF, 0, 0, 0, 0, 0, 0);
    checkOutput("lit_rd_ready", 64'(bus.req_ready), 64'h1);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("lit_rd_t1", 64'(bus.rsp_valid), 64'h0);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("lit_rd_t2", 64'(bus.rsp_valid), 64'h1);
    checkOutput("lit_rd_t2_data", 64'(bus.rsp_rdata), 64'hDEAD_BEEF);

    // run together with a request; doneA leads doneB by five cycles.
    applyStimulus(0, 2'b01, 2'b00, 10'h055, 0, 0, 0, 1, 0, 0);
    checkOutput("lit_run_ready", 64'(bus.req_ready), 64'h0);
    checkOutput("lit_run_busy",  64'(busy), 64'h1);
    applyStimulus(0, 2'b01, 2'b00, 10'h055, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 2'b01, 2'b00, 10'h055, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 2'b01, 2'b00, 10'h055, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 2'b01, 2'b00, 10'h055, 0, 0, 0, 0, 1, 1);
    checkOutput("lit_run_hold", 64'(bus.req_ready), 64'h0);
    checkOutput("lit_run_hold_busy", 64'(busy), 64'h1);
    applyStimulus(0, 2'b01, 2'b00, 10'h055, 0, 0, 0, 0, 0, 0);
    checkOutput("lit_run_exit", 64'(bus.req_ready), 64'h1);
    checkOutput("lit_run_exit_busy", 64'(busy), 64'h0);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("lit_run_rsp_data", 64'(bus.rsp_rdata), 64'hC0DE_0055);

    // Stale done levels at run time must not end the run; run in RUN ignored.
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 1);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 2'b01, 2'b00, 10'h066, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 2'b01, 2'b00, 10'h066, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 2'b01, 2'b00, 10'h066, 0, 0, 0, 0, 0, 0);
    checkOutput("lit_stale_busy",  64'(busy), 64'h1);
    checkOutput("lit_stale_ready", 64'(bus.req_ready), 64'h0);
    applyStimulus(0, 2'b01, 2'b00, 10'h066, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 2'b01, 2'b00, 10'h066, 0, 0, 0, 0, 1, 1);
    checkOutput("lit_stale_busy2", 64'(busy), 64'h1);
    applyStimulus(0, 2'b01, 2'b00, 10'h066, 0, 0, 0, 0, 1, 1);
    checkOutput("lit_stale_exit", 64'(bus.req_ready), 64'h1);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);

    // Read in flight when run is taken still returns on time.
    applyStimulus(0, 2'b10, 2'b00, 0, 10'h020, 0, 0, 0, 0, 0);
    checkOutput("lit_fly_ready", 64'(bus.req_ready), 64'h2);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("lit_fly_rsp",  64'(bus.rsp_valid), 64'h2);
    checkOutput("lit_fly_data", 64'(bus.rsp_rdata), 64'hC0DE_0020);
    checkOutput("lit_fly_busy", 64'(busy), 64'h1);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("lit_fly_idle", 64'(busy), 64'h0);

    // Reset right after a read: response dropped, pointer back to 0.
    applyStimulus(0, 2'b11, 2'b00, 10'h010, 10'h020, 0, 0, 0, 0, 0);
    checkOutput("lit_rst_pre", 64'(bus.req_ready), 64'h1);
    applyStimulus(1, 2'b11, 2'b00, 10'h010, 10'h020, 0, 0, 0, 0, 0);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("lit_rst_norsp", 64'(bus.rsp_valid), 64'h0);
    applyStimulus(0, 2'b11, 2'b00, 10'h010, 10'h020, 0, 0, 0, 0, 0);
    checkOutput("lit_rst_ptr", 64'(bus.req_ready), 64'h1);

    // Mixed reads and writes from both requesters.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 2'b11, {1'b0, i[0]}, 10'(i), 10'(i + 1),
                    32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i), 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xmem_port_arb.md
XMEM_PORT_ARB -- requirements
Module: xmem_port_arb

Interface
REQ-001 Parameter N_REQ, default 2, number of requesters sharing the xmem host port (2..8).
REQ-002 Parameter DATA_W, default 32, data width, equal to the xmem DATA_W.
REQ-003 Parameter ADDR_W, default 10, word address width, equal to `MEM_ADDR_W.
REQ-004 The block SHALL have an asynchronous, active-high reset rst and a clock clk.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  reset.
REQ-007 run  in  1  engine start pulse, also routed to xmem run.
REQ-008 doneA, doneB  in  1 each  xmem address-generator done flags.
REQ-009 req_valid  in  N_REQ  per-requester access request.
REQ-010 req_we  in  N_REQ  per-requester write (1) or read (0).
REQ-011 req_addr  in  N_REQ*ADDR_W  packed addresses; requester i occupies slice i.
REQ-012 req_wdata  in  N_REQ*DATA_W  packed write data.
REQ-013 req_ready  out  N_REQ  one-hot grant (accept) strobe.
REQ-014 rsp_valid  out  N_REQ  one-hot read-response strobe.
REQ-015 rsp_rdata  out  DATA_W  read data; valid only with a rsp_valid bit.
REQ-016 mem_valid, mem_we  out  1 each  drive xmem valid and we.
REQ-017 mem_addr  out  ADDR_W  drives xmem addr.
REQ-018 mem_wdata  out  DATA_W  drives xmem rdata (write data).
REQ-019 mem_q  in  DATA_W  xmem port-A output (flow_out upper half).
REQ-020 busy  out  1  high while the engine owns the memory.

Function
REQ-021 The controller SHALL have two states: IDLE (host port arbitrated) and RUN (engine active, no grants).
REQ-022 In IDLE, with run=0 and at least one req_valid bit set, exactly one requester SHALL be granted per cycle, round-robin.
REQ-023 The round-robin pointer SHALL advance to (granted index + 1) mod N_REQ after each grant, and SHALL be unchanged in cycles without a grant.
REQ-024 A transfer SHALL occur in a cycle when req_valid[i] and req_ready[i] are both high.
REQ-025 req_ready, mem_valid, mem_we, mem_addr and mem_wdata SHALL be combinational from the request inputs and the state (zero-latency grant).
REQ-026 Back-to-back grants SHALL be supported, one per cycle.
REQ-027 When no grant is issued, mem_valid and mem_we SHALL be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-028 Read data latency SHALL be 2 cycles: for a read accepted in cycle t, rsp_valid[i] is high in cycle t+2 with rsp_rdata=mem_q.
REQ-029 Reads SHALL be tracked by a 2-stage pipeline holding {valid, owner index}.
REQ-030 Writes SHALL produce no response.
REQ-031 In a cycle with run=1 and state IDLE, no grant SHALL be issued, and the state SHALL become RUN in the next cycle.
REQ-032 run has priority over all requests.
REQ-033 busy SHALL equal (state==RUN) OR run.
REQ-034 In RUN, sticky flags SHALL capture doneA and doneB, sampling only from the second RUN cycle onward so that stale done levels from the previous run are ignored.
REQ-035 When both sticky flags are set, the state SHALL return to IDLE in the next cycle, with the flags cleared; grants resume in that IDLE cycle.
REQ-036 run asserted while in RUN SHALL be ignored.
REQ-037 Read responses already in the pipeline when run is taken SHALL still be delivered on schedule.
REQ-038 Pending requests SHALL simply wait, with req_ready=0, throughout RUN; nothing is dropped.

Reset
REQ-039 On rst: state=IDLE, RR pointer=0, sticky done flags=0, read pipeline valids=0.
REQ-040 On rst, all outputs SHALL be 0.
REQ-041 Reset mid-operation SHALL discard in-flight read responses; no rsp_valid pulse SHALL follow the reset.

Structure
REQ-042 The state encoding and the response latency constant (XMEM_RD_LAT=2) SHALL be defined in xmemdefs.vh.
REQ-043 Round-robin selection SHALL be a sub-module xrr_arb (inputs: req vector and pointer; output: one-hot grant), reusable by other shared Versat ports.

Verification
REQ-044 Two requesters both valid continuously, reads to 0x010/0x020 -> grants alternate 0,1,0,1; each rsp_valid 2 cycles after its grant, with the correct data.
REQ-045 Requester 1 writes 0xDEADBEEF to 0x3FF, then requester 0 reads 0x3FF -> read returns 0xDEADBEEF at t+2 to requester 0 only.
REQ-046 run pulse in the same cycle as req_valid=1 -> no grant that cycle, busy=1; request is held until doneA and doneB are both seen (doneA 5 cycles before doneB), then granted in the first IDLE cycle.
REQ-047 doneA=doneB=1 already high when run is pulsed -> RUN is not exited on the stale level; exit occurs only after the done flags drop and reassert.
REQ-048 Read accepted at t, run at t+1 -> rsp_valid still arrives at t+2 while busy=1.
REQ-049 Read accepted at t, rst at t+1 -> no rsp_valid; all outputs 0; the next grant goes to requester 0.
